// File: rtl/subtractor_module_pkg.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_module_pkg
// Description : Shared widths and FSM state encoding for the subtractor.
// Revision    : 1.0
// ============================================================================
package subtractor_module_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage : subtractor_module_pkg
`default_nettype wire

// File: rtl/subtractor_module_fxp_sub.sv
`default_nettype none
// ============================================================================
// Module      : fxp_sub
// Description : Combinational fixed-point subtractor, result modulo 2^DATA_W.
// Revision    : 1.0
// ============================================================================
module fxp_sub
    import subtractor_module_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] diff
);

    // Both operands share the same binary point, so no alignment is needed.
    assign diff = a - b;

endmodule : fxp_sub
`default_nettype wire

// File: rtl/subtractor_module.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_module
// Description : IDLE/READ/WRITE sequencer producing one registered Q12.4
//               difference every two cycles.
// Revision    : 1.0
// ============================================================================
module subtractor_module
    import subtractor_module_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] entry_1,
    input  logic [DATA_W-1:0] entry_2,
    output logic              rd,
    output logic              wr,
    output logic [DATA_W-1:0] output_1
);

    state_t            r_state;
    logic              r_rd;
    logic              r_wr;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] w_diff;

    fxp_sub u_fxp_sub (
        .a    (entry_1),
        .b    (entry_2),
        .diff (w_diff)
    );

    // Strobes are registered alongside the state so they never depend on inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_state <= READ;
                    r_rd    <= 1'b1;
                    r_wr    <= 1'b0;
                end
                READ: begin
                    r_state  <= WRITE;
                    r_rd     <= 1'b0;
                    r_wr     <= 1'b1;
                    r_result <= w_diff;
                end
                WRITE: begin
                    r_state <= READ;
                    r_rd    <= 1'b1;
                    r_wr    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_rd    <= 1'b0;
                    r_wr    <= 1'b0;
                end
            endcase
        end
    end

    assign rd       = r_rd;
    assign wr       = r_wr;
    assign output_1 = r_result;

endmodule : subtractor_module
`default_nettype wire

// File: tb/tb_subtractor_module.sv
`default_nettype none
// ============================================================================
// Module      : tb_subtractor_module
// Description : Directed self-checking bench for subtractor_module.
// Revision    : 1.0
// ============================================================================
module tb_subtractor_module;

    logic        clk;
    logic        reset;
    logic [15:0] entry_1;
    logic [15:0] entry_2;
    logic        rd;
    logic        wr;
    logic [15:0] output_1;

    int n_cmp;
    int n_err;

    subtractor_module dut (
        .clk      (clk),
        .reset    (reset),
        .entry_1  (entry_1),
        .entry_2  (entry_2),
        .rd       (rd),
        .wr       (wr),
        .output_1 (output_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic r, input logic w, input logic [15:0] o);
        chk({tag, ".rd"}, {15'd0, rd}, {15'd0, r});
        chk({tag, ".wr"}, {15'd0, wr}, {15'd0, w});
        chk({tag, ".out"}, output_1, o);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset   = 1'b1;
        entry_1 = 16'h1234;
        entry_2 = 16'h0001;

        // Held reset keeps everything cleared, whatever the inputs.
        tick(); chk_all("rst1", 1'b0, 1'b0, 16'h0000);
        tick(); chk_all("rst2", 1'b0, 1'b0, 16'h0000);

        // First cycle after release is IDLE, then READ.
        reset = 1'b0;
        tick(); chk_all("read1", 1'b1, 1'b0, 16'h0000);
        entry_1 = 16'h0065; entry_2 = 16'h0047;
        tick(); chk_all("write1", 1'b0, 1'b1, 16'h001E);

        entry_1 = 16'h00C7; entry_2 = 16'h0053;
        tick(); chk_all("read2", 1'b1, 1'b0, 16'h001E);
        tick(); chk_all("write2", 1'b0, 1'b1, 16'h0074);

        entry_1 = 16'h0C84; entry_2 = 16'h0965;
        tick(); chk_all("read3", 1'b1, 1'b0, 16'h0074);
        tick(); chk_all("write3", 1'b0, 1'b1, 16'h031F);

        // Negative result wraps.
        entry_1 = 16'h0000; entry_2 = 16'h0001;
        tick(); chk_all("read4", 1'b1, 1'b0, 16'h031F);
        tick(); chk_all("wrap", 1'b0, 1'b1, 16'hFFFF);

        // Values present only during WRITE must be ignored.
        entry_1 = 16'h1111; entry_2 = 16'h0011;
        tick(); chk_all("ignore", 1'b1, 1'b0, 16'hFFFF);
        entry_1 = 16'h0200; entry_2 = 16'h0100;
        tick(); chk_all("write5", 1'b0, 1'b1, 16'h0100);

        // Reset during WRITE.
        reset = 1'b1;
        entry_1 = 16'h8000; entry_2 = 16'h0001;
        tick(); chk_all("rstw", 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        tick(); chk_all("resume", 1'b1, 1'b0, 16'h0000);
        tick(); chk_all("write6", 1'b0, 1'b1, 16'h7FFF);

        // Reset during READ discards the pending pair.
        tick(); chk_all("read7", 1'b1, 1'b0, 16'h7FFF);
        reset = 1'b1;
        tick(); chk_all("rstr", 1'b0, 1'b0, 16'h0000);
        reset = 1'b0;
        tick(); chk_all("resume2", 1'b1, 1'b0, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_subtractor_module
`default_nettype wire
